// File: rtl/gate_function_identifier.sv
`default_nettype none
// ============================================================================
// Module      : gate_function_identifier
// Description : Drives the four {a,b} probe vectors into a two-input
//               combinational target, samples its response into a truth
//               table and classifies the table as a known two-input gate.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_function_identifier #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_probe_a,
    output logic       o_probe_b,
    input  logic       i_probe_y,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_truth,
    output logic [2:0] o_gate_code,
    output logic       o_valid_gate
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DECODE = 2'd3
    } state_t;

    localparam logic [3:0] c_SETTLE = 4'(SETTLE_CYCLES);
    localparam logic [2:0] c_UNKNOWN = 3'd7;

    // Each vector window is SETTLE_CYCLES+1 cycles long and its last cycle is
    // spent in SAMPLE, so DRIVE covers the first SETTLE_CYCLES cycles. With no
    // settle time a window goes straight to SAMPLE.
    localparam state_t     c_WIN_FIRST = (c_SETTLE == 4'd0) ? S_SAMPLE : S_DRIVE;
    localparam logic [3:0] c_CNT_LOAD  = (c_SETTLE == 4'd0) ? 4'd0 : (c_SETTLE - 4'd1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic [3:0] r_shadow;
    logic       r_probe_a;
    logic       r_probe_b;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_truth;
    logic [2:0] r_gate_code;
    logic       r_valid_gate;
    logic [2:0] w_code;

    // Classify a completed truth table (bit i = response to {a,b}=i).
    function automatic logic [2:0] f_decode(input logic [3:0] t);
        logic [2:0] code;
        case (t)
            4'b1000: code = 3'd0;   // AND
            4'b1110: code = 3'd1;   // OR
            4'b0001: code = 3'd2;   // NOR
            4'b0111: code = 3'd3;   // NAND
            4'b1001: code = 3'd4;   // XNOR
            4'b0110: code = 3'd5;   // XOR
            default: code = c_UNKNOWN;
        endcase
        return code;
    endfunction

    assign w_code = f_decode(r_shadow);

    // Characterisation sequencer: walks the probe vectors, collects the
    // shadow table and publishes results only once the table is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= 4'd0;
            r_shadow     <= 4'd0;
            r_probe_a    <= 1'b0;
            r_probe_b    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_truth      <= 4'd0;
            r_gate_code  <= c_UNKNOWN;
            r_valid_gate <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy    <= 1'b1;
                        r_idx     <= 2'd0;
                        r_probe_a <= 1'b0;
                        r_probe_b <= 1'b0;
                        r_cnt     <= c_CNT_LOAD;
                        r_state   <= c_WIN_FIRST;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_shadow[r_idx] <= i_probe_y;
                    if (r_idx == 2'd3) begin
                        r_state <= S_DECODE;
                    end else begin
                        r_idx                  <= r_idx + 2'd1;
                        {r_probe_a, r_probe_b} <= r_idx + 2'd1;
                        r_cnt                  <= c_CNT_LOAD;
                        r_state                <= c_WIN_FIRST;
                    end
                end
                S_DECODE: begin
                    r_truth      <= r_shadow;
                    r_gate_code  <= w_code;
                    r_valid_gate <= (w_code != c_UNKNOWN);
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_probe_a    <= 1'b0;
                    r_probe_b    <= 1'b0;
                    r_idx        <= 2'd0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_probe_a    = r_probe_a;
    assign o_probe_b    = r_probe_b;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_truth      = r_truth;
    assign o_gate_code  = r_gate_code;
    assign o_valid_gate = r_valid_gate;

endmodule
`default_nettype wire

// File: tb/tb_gate_function_identifier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gate_function_identifier
// Description : Scoreboard bench for gate_function_identifier. Three DUTs with
//               settle times 1, 0 and 15 each probe a table-defined target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_function_identifier;

    typedef struct {
        int         inst;
        int         e0;
        logic [3:0] tt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] pa, pb, py, busy, done, valid;
    logic [3:0] truth [3];
    logic [2:0] code  [3];
    logic [3:0] tgt   [3];

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   next_free [3];
    logic seq_err = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
    endfunction

    function automatic int lat(input int i);
        return 4 * (s_of(i) + 1) + 1;
    endfunction

    // Reference classifier: position in the list of known tables is the code.
    function automatic int ref_code(input logic [3:0] tt);
        logic [3:0] known [6];
        known = '{4'b1000, 4'b1110, 4'b0001, 4'b0111, 4'b1001, 4'b0110};
        for (int i = 0; i < 6; i++) if (known[i] == tt) return i;
        return 7;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        gate_function_identifier #(
            .SETTLE_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 15))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_start      (start[gi]),
            .o_probe_a    (pa[gi]),
            .o_probe_b    (pb[gi]),
            .i_probe_y    (py[gi]),
            .o_busy       (busy[gi]),
            .o_done       (done[gi]),
            .o_truth      (truth[gi]),
            .o_gate_code  (code[gi]),
            .o_valid_gate (valid[gi])
        );
        // Target gate: its own truth table looked up by the probe vector.
        assign py[gi] = tgt[gi][{pa[gi], pb[gi]}];
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: checks reset values while reset is low, probe/busy timing of the
    // run at the queue head, and every done pulse against the scoreboard.
    initial begin : p_monitor
        exp_t e;
        int   d, s, k;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                sb.delete();
                seq_err = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    chk("rst_probes", int'({pa[i], pb[i]}), 0);
                    chk("rst_busy", int'(busy[i]), 0);
                    chk("rst_done", int'(done[i]), 0);
                    chk("rst_truth", int'(truth[i]), 0);
                    chk("rst_code", int'(code[i]), 7);
                    chk("rst_valid", int'(valid[i]), 0);
                end
            end else begin
                if (sb.size() > 0) begin
                    e = sb[0];
                    d = cyc - e.e0;
                    s = s_of(e.inst);
                    if (d >= 0 && d <= 4 * (s + 1)) begin
                        k = (d < 4 * (s + 1)) ? d / (s + 1) : 3;
                        if (int'({pa[e.inst], pb[e.inst]}) != k || busy[e.inst] !== 1'b1)
                            seq_err = 1'b1;
                    end
                    if (d > lat(e.inst) + 4) begin
                        checks++;
                        failures++;
                        $display("FAIL done_timeout inst=%0d actual=none required=done_at_%0d", e.inst, lat(e.inst));
                        void'(sb.pop_front());
                        seq_err = 1'b0;
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (done[i] === 1'b1) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done inst=%0d actual=1 required=0", i);
                        end else begin
                            e = sb.pop_front();
                            chk("done_inst", i, e.inst);
                            chk("done_latency", cyc - e.e0, lat(i));
                            chk("truth", int'(truth[i]), int'(e.tt));
                            chk("gate_code", int'(code[i]), ref_code(e.tt));
                            chk("valid_gate", int'(valid[i]), (ref_code(e.tt) != 7) ? 1 : 0);
                            chk("busy_at_done", int'(busy[i]), 0);
                            chk("probes_at_done", int'({pa[i], pb[i]}), 0);
                            chk("probe_sequence", int'(seq_err), 0);
                            seq_err = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the model accepts start only when the unit is idle.
    task automatic tick(input int inst, input logic s);
        exp_t t;
        @(negedge clk);
        start[inst] = s;
        if (s && (cyc + 1 >= next_free[inst])) begin
            t.inst = inst;
            t.e0   = cyc + 1;
            t.tt   = tgt[inst];
            sb.push_back(t);
            next_free[inst] = cyc + 1 + lat(inst) + 1;
        end
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick(inst, 1'b0);
            n++;
        end
        if (sb.size() != 0) begin
            $display("FAIL wait_idle inst=%0d actual=pending required=empty", inst);
            $fatal(1, "scoreboard never drained");
        end
        tick(inst, 1'b0);
    endtask

    task automatic run(input int inst, input logic [3:0] tt);
        tgt[inst] = tt;
        tick(inst, 1'b1);
        tick(inst, 1'b0);
        wait_idle(inst);
    endtask

    initial begin : p_stim
        int         ri;
        logic [3:0] rt;
        for (int i = 0; i < 3; i++) begin
            tgt[i]       = 4'b0000;
            next_free[i] = 0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 4'b1000);                    // AND
        run(0, 4'b1001);                    // XNOR
        run(0, 4'b0110);                    // XOR
        run(0, 4'b0001);                    // NOR
        run(0, 4'b1111);                    // constant 1
        run(0, 4'b1100);                    // follows a

        // start held high continuously on the zero-settle unit
        tgt[1] = 4'b0110;
        for (int i = 0; i < 20; i++) tick(1, 1'b1);
        tick(1, 1'b0);
        wait_idle(1);

        // start pulses mid-run must not restart the sequence
        tgt[0] = 4'b0111;
        tick(0, 1'b1);
        for (int i = 0; i < 8; i++) tick(0, 1'(i % 2));
        tick(0, 1'b0);
        wait_idle(0);

        // reset during the vector-2 window of an OR run
        tgt[0] = 4'b1110;
        tick(0, 1'b1);
        repeat (5) tick(0, 1'b0);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) next_free[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick(0, 1'b0);
        run(0, 4'b1110);

        // long settle, NAND
        run(2, 4'b0111);

        // random tables on the short-settle units
        for (int i = 0; i < 10; i++) begin
            ri = $urandom_range(0, 1);
            rt = 4'($urandom_range(0, 15));
            run(ri, rt);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
